// File: rtl/vga_sync_pkg.sv
`default_nettype none
// ============================================================================
// Package  : vga_sync_pkg
// Purpose  : shared FSM encoding, 640x480 timing constants, counter helper
// Revision : 1.0
// ============================================================================
package vga_sync_pkg;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } sync_state_t;

    localparam int H_ACTIVE_640 = 640;
    localparam int H_TOTAL_800  = 800;
    localparam int V_ACTIVE_480 = 480;
    localparam int V_TOTAL_525  = 525;

    function automatic logic [9:0] sat_inc10(input logic [9:0] v);
        return (v == 10'h3FF) ? v : v + 10'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_edge_detect.sv
`default_nettype none
// ============================================================================
// Module   : sync_edge_detect
// Purpose  : two-stage input register with rise/fall pulses from _q vs _qq
// Revision : 1.0
// ============================================================================
module sync_edge_detect #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q,
    output logic o_rise,
    output logic o_fall
);

    logic sig_q;
    logic sig_qq;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig_q  <= RESET_VAL;
            sig_qq <= RESET_VAL;
        end else begin
            sig_q  <= i_d;
            sig_qq <= sig_q;
        end
    end

    assign o_q    = sig_q;
    assign o_rise = sig_q & ~sig_qq;
    assign o_fall = ~sig_q & sig_qq;

endmodule
`default_nettype wire

// File: rtl/vga_sync_decoder.sv
`default_nettype none
// ============================================================================
// Module   : vga_sync_decoder
// Purpose  : rebuilds drawX/drawY from hs/vs/blank, measures geometry, locks
// Revision : 1.0
// ============================================================================
module vga_sync_decoder
    import vga_sync_pkg::*;
#(
    parameter int H_ACTIVE    = H_ACTIVE_640,
    parameter int V_ACTIVE    = V_ACTIVE_480,
    parameter int H_TOTAL     = H_TOTAL_800,
    parameter int V_TOTAL     = V_TOTAL_525,
    parameter int LOCK_FRAMES = 2
) (
    input  logic       pixel_clk,
    input  logic       reset,
    input  logic       hs,
    input  logic       vs,
    input  logic       active_nblank,
    output logic [9:0] drawX,
    output logic [9:0] drawY,
    output logic       pixel_valid,
    output logic       new_frame,
    output logic       locked,
    output logic       sync_err,
    output logic [9:0] h_total_meas,
    output logic [9:0] v_total_meas
);

    localparam int              GOOD_W     = $clog2(LOCK_FRAMES + 1);
    localparam logic [9:0]      c_h_active = 10'(H_ACTIVE);
    localparam logic [9:0]      c_h_total  = 10'(H_TOTAL);
    localparam logic [9:0]      c_v_active = 10'(V_ACTIVE);
    localparam logic [9:0]      c_v_total  = 10'(V_TOTAL);
    localparam logic [GOOD_W-1:0] c_lock   = GOOD_W'(LOCK_FRAMES);

    logic hs_q, vs_q, an_q;
    logic w_hs_rise, w_hs_fall, w_vs_rise, w_vs_fall, w_an_rise, w_an_fall;

    sync_edge_detect #(.RESET_VAL(1'b1)) u_hs_edge (
        .clk(pixel_clk), .rst(reset), .i_d(hs),
        .o_q(hs_q), .o_rise(w_hs_rise), .o_fall(w_hs_fall)
    );

    sync_edge_detect #(.RESET_VAL(1'b1)) u_vs_edge (
        .clk(pixel_clk), .rst(reset), .i_d(vs),
        .o_q(vs_q), .o_rise(w_vs_rise), .o_fall(w_vs_fall)
    );

    sync_edge_detect #(.RESET_VAL(1'b0)) u_an_edge (
        .clk(pixel_clk), .rst(reset), .i_d(active_nblank),
        .o_q(an_q), .o_rise(w_an_rise), .o_fall(w_an_fall)
    );

    logic w_unused;
    assign w_unused = ^{hs_q, w_hs_rise, w_vs_rise};

    logic [9:0] h_cnt_q, h_cnt_d;
    logic [9:0] h_total_meas_q, h_total_meas_d;
    logic       h_seen_q, h_seen_d;
    logic [9:0] line_cnt_q, line_cnt_d;
    logic [9:0] v_total_meas_q, v_total_meas_d;
    logic [9:0] act_lines_q, act_lines_d;
    logic [9:0] run_len_q, run_len_d;
    logic       run_bad_q, run_bad_d;
    logic       frame_bad_q, frame_bad_d;
    logic [9:0] draw_x_q, draw_x_d;
    logic [9:0] draw_y_q, draw_y_d;

    logic [9:0] w_h_next, w_lines_cur, w_act_cur;
    logic       w_run_bad, w_line_bad, w_frame_bad;
    logic       w_an_rise_now, w_an_fall_now, w_vs_fall_now;

    always_comb begin
        w_h_next    = sat_inc10(h_cnt_q);
        w_run_bad   = run_bad_q | (w_an_fall & (run_len_q != c_h_active));
        w_line_bad  = w_hs_fall & h_seen_q & ((w_h_next != c_h_total) | w_run_bad);
        // A coincident hs edge / active start belongs to the frame being closed.
        w_lines_cur = w_hs_fall ? sat_inc10(line_cnt_q) : line_cnt_q;
        w_act_cur   = w_an_rise ? sat_inc10(act_lines_q) : act_lines_q;
        w_frame_bad = frame_bad_q | w_line_bad | (w_lines_cur != c_v_total)
                    | (w_act_cur != c_v_active);

        // Edges of the _q stage itself, so drawX/drawY carry one cycle of latency.
        w_an_rise_now = active_nblank & ~an_q;
        w_an_fall_now = ~active_nblank & an_q;
        w_vs_fall_now = ~vs & vs_q;

        h_cnt_d        = w_hs_fall ? 10'd0 : w_h_next;
        h_total_meas_d = w_hs_fall ? w_h_next : h_total_meas_q;
        h_seen_d       = h_seen_q | w_hs_fall;
        run_bad_d      = w_hs_fall ? 1'b0 : w_run_bad;
        line_cnt_d     = w_vs_fall ? 10'd0 : w_lines_cur;
        v_total_meas_d = w_vs_fall ? w_lines_cur : v_total_meas_q;
        act_lines_d    = w_vs_fall ? 10'd0 : w_act_cur;
        frame_bad_d    = w_vs_fall ? 1'b0 : (frame_bad_q | w_line_bad);

        if (w_an_rise) begin
            run_len_d = 10'd1;
        end else if (an_q) begin
            run_len_d = sat_inc10(run_len_q);
        end else begin
            run_len_d = run_len_q;
        end

        if (w_an_rise_now) begin
            draw_x_d = 10'd0;
        end else if (active_nblank) begin
            draw_x_d = draw_x_q + 10'd1;
        end else begin
            draw_x_d = draw_x_q;
        end

        if (w_vs_fall_now) begin
            draw_y_d = 10'd0;
        end else if (w_an_fall_now) begin
            draw_y_d = sat_inc10(draw_y_q);
        end else begin
            draw_y_d = draw_y_q;
        end
    end

    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            h_cnt_q        <= '0;
            h_total_meas_q <= '0;
            h_seen_q       <= 1'b0;
            line_cnt_q     <= '0;
            v_total_meas_q <= '0;
            act_lines_q    <= '0;
            run_len_q      <= '0;
            run_bad_q      <= 1'b0;
            frame_bad_q    <= 1'b0;
            draw_x_q       <= '0;
            draw_y_q       <= '0;
        end else begin
            h_cnt_q        <= h_cnt_d;
            h_total_meas_q <= h_total_meas_d;
            h_seen_q       <= h_seen_d;
            line_cnt_q     <= line_cnt_d;
            v_total_meas_q <= v_total_meas_d;
            act_lines_q    <= act_lines_d;
            run_len_q      <= run_len_d;
            run_bad_q      <= run_bad_d;
            frame_bad_q    <= frame_bad_d;
            draw_x_q       <= draw_x_d;
            draw_y_q       <= draw_y_d;
        end
    end

    sync_state_t       state_q;
    logic [GOOD_W-1:0] good_cnt_q;
    logic              locked_q, sync_err_q, new_frame_q;

    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            state_q     <= SEARCH;
            good_cnt_q  <= '0;
            locked_q    <= 1'b0;
            sync_err_q  <= 1'b0;
            new_frame_q <= 1'b0;
        end else begin
            sync_err_q  <= 1'b0;
            new_frame_q <= w_vs_fall;
            case (state_q)
                SEARCH: begin
                    if (w_vs_fall) begin
                        state_q    <= MEASURE;
                        good_cnt_q <= '0;
                    end
                end
                MEASURE: begin
                    if (w_vs_fall) begin
                        if (w_frame_bad) begin
                            sync_err_q <= 1'b1;
                            state_q    <= SEARCH;
                        end else if (good_cnt_q + GOOD_W'(1) == c_lock) begin
                            locked_q <= 1'b1;
                            state_q  <= LOCKED;
                        end else begin
                            good_cnt_q <= good_cnt_q + GOOD_W'(1);
                        end
                    end
                end
                LOCKED: begin
                    if ((w_vs_fall & w_frame_bad) | w_line_bad) begin
                        sync_err_q <= 1'b1;
                        locked_q   <= 1'b0;
                        state_q    <= SEARCH;
                    end
                end
                default: begin
                    locked_q <= 1'b0;
                    state_q  <= SEARCH;
                end
            endcase
        end
    end

    assign drawX        = draw_x_q;
    assign drawY        = draw_y_q;
    assign pixel_valid  = an_q & locked_q;
    assign new_frame    = new_frame_q;
    assign locked       = locked_q;
    assign sync_err     = sync_err_q;
    assign h_total_meas = h_total_meas_q;
    assign v_total_meas = v_total_meas_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_sync_decoder
// Purpose  : directed bench on a scaled-down raster (100x12, 64x8 active)
// Revision : 1.0
// ============================================================================
module tb_vga_sync_decoder;

    localparam int HA         = 64;
    localparam int VA         = 8;
    localparam int HT         = 100;
    localparam int VT         = 12;
    localparam int HS_START   = 70;
    localparam int HS_END     = 82;
    localparam int VS_START   = 9;
    localparam int VS_END     = 11;
    localparam int ODD_VC     = 2;
    localparam int BUDGET     = 4000;

    logic       pixel_clk = 1'b0;
    logic       reset = 1'b0;
    logic       hs = 1'b1;
    logic       vs = 1'b1;
    logic       active_nblank = 1'b0;
    logic [9:0] drawX, drawY, h_total_meas, v_total_meas;
    logic       pixel_valid, new_frame, locked, sync_err;

    int checks = 0;
    int failures = 0;
    int err_pulses = 0;
    int gen_hc = 0;
    int gen_vc = 0;
    int frame_lines = VT;
    bit paused = 1'b1;
    bit stretch_on = 1'b0;

    vga_sync_decoder #(
        .H_ACTIVE(HA), .V_ACTIVE(VA), .H_TOTAL(HT), .V_TOTAL(VT), .LOCK_FRAMES(2)
    ) dut (
        .pixel_clk    (pixel_clk),
        .reset        (reset),
        .hs           (hs),
        .vs           (vs),
        .active_nblank(active_nblank),
        .drawX        (drawX),
        .drawY        (drawY),
        .pixel_valid  (pixel_valid),
        .new_frame    (new_frame),
        .locked       (locked),
        .sync_err     (sync_err),
        .h_total_meas (h_total_meas),
        .v_total_meas (v_total_meas)
    );

    always #5 pixel_clk = ~pixel_clk;

    always @(negedge pixel_clk) begin
        if (sync_err === 1'b1) err_pulses <= err_pulses + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive one pixel from the raster position, clock it, then advance.
    task automatic tick();
        int len;
        if (paused) begin
            hs = 1'b1; vs = 1'b1; active_nblank = 1'b0;
        end else begin
            hs = !(gen_hc >= HS_START && gen_hc < HS_END);
            vs = !(gen_vc >= VS_START && gen_vc < VS_END);
            active_nblank = (gen_hc < HA) && (gen_vc < VA);
        end
        @(posedge pixel_clk);
        #1;
        if (!paused) begin
            len = (stretch_on && gen_vc == ODD_VC) ? HT + 1 : HT;
            if (gen_hc == len - 1) begin
                gen_hc = 0;
                gen_vc = (gen_vc == frame_lines - 1) ? 0 : gen_vc + 1;
            end else begin
                gen_hc++;
            end
        end
    endtask

    task automatic run_until(input string tag, input int v, input int h);
        bit hit = 1'b0;
        int n = 0;
        while (!hit && n < BUDGET) begin
            hit = (gen_vc == v && gen_hc == h);
            tick();
            n++;
        end
        if (!hit) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_vs_edge(input string tag, input int exp_locked);
        run_until(tag, VS_START, 0);
        tick();
        check({tag, "_new_frame"}, 32'(new_frame), 32'd1);
        check({tag, "_locked"}, 32'(locked), 32'(exp_locked));
    endtask

    task automatic check_in_reset(input string tag);
        check({tag, "_flags"}, 32'({pixel_valid, new_frame, locked, sync_err}), 32'd0);
        check({tag, "_counts"}, 32'(|{drawX, drawY, h_total_meas, v_total_meas}), 32'd0);
    endtask

    initial begin
        #2 reset = 1'b1;
        repeat (3) begin
            tick();
            check_in_reset("por");
        end
        reset = 1'b0;
        paused = 1'b0;

        // Lock from reset: SEARCH -> MEASURE -> 1 good -> 2 good (LOCKED)
        wait_vs_edge("f0", 0);
        tick();
        check("new_frame_width", 32'(new_frame), 32'd0);
        wait_vs_edge("f1", 0);
        wait_vs_edge("f2", 1);
        check("lock_h_meas", 32'(h_total_meas), HT);
        check("lock_v_meas", 32'(v_total_meas), VT);

        run_until("px00", 0, 0);
        check("px00_x", 32'(drawX), 32'd0);
        check("px00_y", 32'(drawY), 32'd0);
        check("px00_valid", 32'(pixel_valid), 32'd1);
        run_until("pxlast", VA - 1, HA - 1);
        check("pxlast_x", 32'(drawX), HA - 1);
        check("pxlast_y", 32'(drawY), VA - 1);
        check("pxlast_valid", 32'(pixel_valid), 32'd1);
        tick();
        check("blank_valid", 32'(pixel_valid), 32'd0);
        check("blank_x_hold", 32'(drawX), HA - 1);
        check("blank_y_inc", 32'(drawY), VA);
        wait_vs_edge("f3", 1);
        check("clean_err_count", 32'(err_pulses), 32'd0);

        // One 101-clock line while locked
        stretch_on = 1'b1;
        run_until("stretch", ODD_VC + 1, HS_START);
        tick();
        check("stretch_err", 32'(sync_err), 32'd1);
        check("stretch_locked", 32'(locked), 32'd0);
        check("stretch_h_meas", 32'(h_total_meas), HT + 1);
        stretch_on = 1'b0;
        wait_vs_edge("s0", 0);
        wait_vs_edge("s1", 0);
        wait_vs_edge("s2", 1);
        check("stretch_err_count", 32'(err_pulses), 32'd1);

        // Frame one line short while locked
        frame_lines = VT - 1;
        wait_vs_edge("drop", 0);
        check("drop_err", 32'(sync_err), 32'd1);
        check("drop_v_meas", 32'(v_total_meas), VT - 1);
        frame_lines = VT;
        wait_vs_edge("d0", 0);
        wait_vs_edge("d1", 0);
        wait_vs_edge("d2", 1);
        check("drop_err_count", 32'(err_pulses), 32'd2);

        // Mid-frame reset while locked
        run_until("mid", 4, 30);
        reset = 1'b1;
        #1;
        check("rst_async_locked", 32'(locked), 32'd0);
        repeat (3) begin
            tick();
            check_in_reset("mid_rst");
        end
        reset = 1'b0;
        wait_vs_edge("r0", 0);
        wait_vs_edge("r1", 0);
        wait_vs_edge("r2", 1);

        // hs held high for 2000 extra clocks
        run_until("hold", ODD_VC, 89);
        paused = 1'b1;
        repeat (2000) tick();
        check("hold_h_meas_idle", 32'(h_total_meas), HT);
        paused = 1'b0;
        run_until("hold_end", ODD_VC + 1, HS_START);
        tick();
        check("hold_err", 32'(sync_err), 32'd1);
        check("hold_h_meas_sat", 32'(h_total_meas), 32'd1023);
        check("hold_locked", 32'(locked), 32'd0);
        tick();
        tick();
        check("final_err_count", 32'(err_pulses), 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vga_sync_decoder.md
# vga_sync_decoder

Video timing receiver for the HDMI display path: consumes the `hs`/`vs`/`active_nblank` triple that `vga_controller` produces and reconstructs pixel coordinates from the sync stream alone. It measures line and frame geometry and reports lock against the 640x480@60 timing. It regenerates `drawX`/`drawY` for downstream consumers: frame capture, overlay checkers, and a loopback self-test of the video pipeline. It sits on the 25 MHz pixel clock domain next to the VGA generator.

## Interface
- `H_ACTIVE`, 640, active pixels per line
- `V_ACTIVE`, 480, active lines per frame
- `H_TOTAL`, 800, pixel clocks per line
- `V_TOTAL`, 525, lines per frame
- `LOCK_FRAMES`, 2, consecutive good frames required to assert lock
- `pixel_clk`  in  1  pixel clock. The block uses this single clock.
- `reset`  in  1  asynchronous, active-high reset
- `hs`  in  1  horizontal sync, active low
- `vs`  in  1  vertical sync, active low
- `active_nblank`  in  1  display enable, high during active video
- `drawX`  out  10  column index within the current active run
- `drawY`  out  10  active-line index within the current frame
- `pixel_valid`  out  1  registered `active_nblank` AND `locked`
- `new_frame`  out  1  one-cycle pulse on each detected `vs` falling edge
- `locked`  out  1  geometry matches the parameters
- `sync_err`  out  1  one-cycle pulse when a geometry check fails
- `h_total_meas`  out  10  clocks measured between the last two `hs` falling edges
- `v_total_meas`  out  10  `hs` falling edges counted in the last complete frame

## Operation
- Input stage: `hs`, `vs` and `active_nblank` are registered once (`_q`). Edge detection compares `_q` against a second register stage (`_qq`).
- Horizontal counter:
  - Clears to 0 on each `hs` falling edge, after its value is latched into `h_total_meas`.
  - Otherwise increments by 1.
  - Saturates at 1023.
- Line counter:
  - Increments on each `hs` falling edge.
  - On each `vs` falling edge, its value is latched into `v_total_meas`, then it clears to 0.
- `drawX`:
  - Clears to 0 on the rising edge of `active_nblank_q`.
  - Increments while `active_nblank_q`=1.
  - Holds its value otherwise.
- `drawY`:
  - Clears to 0 on a `vs` falling edge.
  - Increments on each falling edge of `active_nblank_q`.
  - Saturates at 1023.
- Active-line counter: counts `active_nblank_q` rising edges per frame, for the `V_ACTIVE` check.
- A line is good when `h_total_meas`==`H_TOTAL` and the active run length on that line is `H_ACTIVE`.
- A frame is good when every line in it is good, `v_total_meas`==`V_TOTAL`, and the active-line count is `V_ACTIVE`.
- FSM states, with `locked`=1 only in LOCKED:
  - SEARCH: wait for a `vs` falling edge, then go to MEASURE with the good-frame count cleared to 0.
  - MEASURE: at each `vs` falling edge, a good frame increments the good-frame count. When the count reaches `LOCK_FRAMES`, go to LOCKED. A bad frame pulses `sync_err` and returns to SEARCH.
  - LOCKED: at each `vs` falling edge, a bad frame pulses `sync_err` and returns to SEARCH. A bad line pulses `sync_err` immediately at that line's `hs` edge.
- Simultaneous `hs` and `vs` falling edges in one cycle: the `hs` edge is counted first, then `v_total_meas` is latched and the line counter clears.
- The very first `hs` edge after reset is not checked, because no prior edge exists to measure from.

## Timing
- Reset values:
  - All outputs are 0 and the FSM is in SEARCH.
  - All counters are 0.
  - `_q` and `_qq` registers reset to 1 for `hs`/`vs` and to 0 for `active_nblank`.
- Latency is 1 `pixel_clk` from input to `drawX`, `drawY` and `pixel_valid`: the first active pixel of a line shows `drawX`=0 one cycle after `active_nblank` rises.
- `new_frame` is asserted 2 cycles after `vs` falls.
- `locked` rises 2 cycles after the `vs` falling edge that completes the `LOCK_FRAMES`-th good frame.
- `locked` falls in the same cycle that `sync_err` pulses.
- Reset asserted mid-frame clears state immediately. After reset is released, the block requires a full SEARCH→MEASURE→LOCKED sequence before `locked` reasserts.

## Structure
- Shared package `vga_sync_pkg`:
  - FSM state enum `sync_state_t` (SEARCH, MEASURE, LOCKED).
  - 640x480 constants (`H_ACTIVE_640`, `H_TOTAL_800`, `V_TOTAL_525`, `V_ACTIVE_480`).
- Sub-module `sync_edge_detect`: two-stage register with rise and fall pulse outputs. It is instantiated three times, once each for `hs`, `vs` and `active_nblank`.

## Test plan
- Driven by `vga_controller` out of reset → `locked`=1 at the end of frame 2, `h_total_meas`=800, `v_total_meas`=525. No `sync_err` pulses over 4 frames.
- While locked, sample at the pixel where the generator outputs X=639, Y=479 → one cycle later `drawX`=639, `drawY`=479, `pixel_valid`=1.
- Stretch one line to 801 clocks while locked → a single `sync_err` pulse, `locked`=0, `h_total_meas`=801. Relock after 2 further clean frames.
- Drop one line from a frame (524 lines) → `sync_err` at that frame's `vs` edge and `v_total_meas`=524.
- Assert `reset` for 3 cycles mid-frame → all outputs 0 during reset, `locked` stays 0 until 2 full frames after the next `vs` edge.
- Hold `hs` high for 2000 clocks → horizontal counter saturates at 1023, no wrap. The next `hs` edge gives `h_total_meas`=1023 and a `sync_err` pulse.
